// File: rtl/tff_counter_seq.sv
// Command sequencer turning an external T flip-flop bank into an up/down counter.
// Optional `TFF_SEQ_HOLD_EN adds a hold_i input that pauses counting.
module tff_counter_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef TFF_SEQ_HOLD_EN
  input  logic             hold_i,
`endif
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic [WIDTH-1:0] t_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q;
  logic [WIDTH-1:0] dreg_q;
  logic [WIDTH-1:0] rem_q;
  logic             dir_up_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap_q;

  logic             step_en;
  logic             wrap_hit;
  logic             accept;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;

`ifdef TFF_SEQ_HOLD_EN
  assign step_en = ~hold_i;
`else
  assign step_en = 1'b1;
`endif

  assign accept   = cmd_valid_i & ready_q;
  assign wrap_hit = dir_up_q ? (&q_in_i) : ~(|q_in_i);

  // Ripple-carry / ripple-borrow toggle chains from the bank feedback
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_in_i[i-1];
      dn_t[i] = dn_t[i-1] & ~q_in_i[i-1];
    end
  end

  always_comb begin
    t_out_o = '0;
    case (state_q)
      S_LOAD:  t_out_o = q_in_i ^ dreg_q;
      S_COUNT: begin
        if (step_en) begin
          t_out_o = dir_up_q ? up_t : dn_t;
        end
      end
      default: t_out_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dreg_q   <= '0;
      rem_q    <= '0;
      dir_up_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            dreg_q  <= cmd_data_i;
            unique case (cmd_op_i)
              OP_LOAD: begin
                state_q <= S_LOAD;
              end
              OP_CLEAR: begin
                dreg_q  <= '0;
                state_q <= S_LOAD;
              end
              OP_UP, OP_DOWN: begin
                dir_up_q <= (cmd_op_i == OP_UP);
                if (cmd_data_i == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  rem_q   <= cmd_data_i;
                  state_q <= S_COUNT;
                end
              end
            endcase
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_COUNT: begin
          if (step_en) begin
            rem_q  <= rem_q - 1'b1;
            wrap_q <= wrap_hit;
            if (rem_q == WIDTH'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_tff_counter_seq.sv
// Scoreboard bench for tff_counter_seq with a behavioural T flip-flop bank.
module tb_tff_counter_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [3:0] bank = 4'h0;
  logic [3:0] t_out;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       hold = 1'b0;

  typedef struct {
    logic [3:0] q;
    int         wc;
    logic       wl;
    int         bc;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         bc = 0;
  int         wc = 0;
  logic [3:0] exp_q = 4'h0;

  always #5 clk = ~clk;

  tff_counter_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef TFF_SEQ_HOLD_EN
    .hold_i      (hold),
`endif
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .q_in_i      (bank),
    .t_out_o     (t_out),
    .busy_o      (busy),
    .done_o      (done),
    .wrap_o      (wrap)
  );

  // Bank of T flip-flops, no reset
  always @(posedge clk) bank <= bank ^ t_out;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!busy) begin
      bc = 0;
      wc = 0;
    end else begin
      bc++;
      if (wrap) wc++;
      if (done) begin
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("done_q", 32'(bank), 32'(e.q));
          check("done_wrap", 32'(wrap), 32'(e.wl));
          check("wrap_cnt", 32'(wc), 32'(e.wc));
          check("busy_cyc", 32'(bc), 32'(e.bc));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] d,
                       input int extra);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    e.wc = 0;
    e.wl = 1'b0;
    case (op)
      2'b00: begin exp_q = d; e.bc = 2; end
      2'b11: begin exp_q = 4'h0; e.bc = 2; end
      default: begin
        for (int i = 0; i < int'(d); i++) begin
          if ((op == 2'b01 && exp_q == 4'hF) ||
              (op == 2'b10 && exp_q == 4'h0)) begin
            e.wc++;
            e.wl = (i == int'(d) - 1);
          end
          exp_q = (op == 2'b01) ? exp_q + 4'h1 : exp_q - 4'h1;
        end
        e.bc = (d == 4'h0) ? 1 : int'(d) + 1;
      end
    endcase
    e.bc += extra;
    e.q = exp_q;
    sb.push_back(e);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_tout", 32'(t_out), 32'd0);
    rst_n = 1'b1;

    issue(2'b00, 4'hA, 0);
    check("load_tout", 32'(t_out), 32'hA);
    drain();

    issue(2'b00, 4'hE, 0);
    issue(2'b01, 4'd3, 0);
    drain();

    issue(2'b10, 4'd2, 0);
    issue(2'b11, 4'h7, 0);
    drain();

    issue(2'b01, 4'd0, 0);
    check("n0_done", 32'(done), 32'd1);
    check("n0_tout", 32'(t_out), 32'd0);
    drain();

    issue(2'b01, 4'd5, 0);
    repeat (2) @(posedge clk);
    #1;
    cmd_op    = 2'b00;
    cmd_data  = 4'h9;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("ignored_q", 32'(bank), 32'h5);
    check("ignored_idle", 32'(busy), 32'd0);

`ifdef TFF_SEQ_HOLD_EN
    issue(2'b11, 4'h0, 0);
    issue(2'b01, 4'd4, 2);
    @(posedge clk);
    #1 hold = 1'b1;
    repeat (2) @(posedge clk);
    #1 hold = 1'b0;
    drain();
`endif

    issue(2'b11, 4'h0, 0);
    drain();
    issue(2'b01, 4'd8, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tout", 32'(t_out), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    exp_q = 4'h3;
    repeat (2) @(negedge clk);
    check("mid_rst_q", 32'(bank), 32'(exp_q));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_q", 32'(bank), 32'(exp_q));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
